i2c_target: RTL

- Synthesizable I2C target (slave) with an internal byte register file.
- It is the responder at the other end of the SoC I2C initiator's bus. It attaches to the unidirectional open-drain pins (scl_i/sda_i/sda_o).
- Used in the Verilator loopback build, and on FPGA as an on-board I2C peripheral.
- Local logic reads the registers through a side port and is notified of every I2C write.

---
 rtl/i2c_target_pkg.sv | 23 ++
 rtl/i2c_target_line_cond.sv | 85 ++++++++
 rtl/i2c_target.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and bus-level constants for the I2C target.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck,
        StIgnore
    } state_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_target_line_cond.sv
// I2C line conditioning: 2-FF synchronizers, optional 3-sample majority filter
// (enabled by I2C_TARGET_GLITCH_FILTER_EN), and SCL edge / START / STOP decode.
module i2c_target_line_cond (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic sda_lvl_o
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_s;
    logic       sda_s;
    logic       scl_lvl;
    logic       sda_lvl;
    logic       scl_prev_q;
    logic       sda_prev_q;

    // Two-flop synchronizers; reset to the idle-bus level so no edge is seen at reset exit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
        end
    end

    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q;
    logic [1:0] sda_hist_q;

    // History of the two previous synced samples of each line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_s};
            sda_hist_q <= {sda_hist_q[0], sda_s};
        end
    end

    // Accept a new level only when three consecutive samples agree; otherwise hold.
    always_comb begin
        scl_lvl = scl_prev_q;
        sda_lvl = sda_prev_q;
        if (scl_hist_q == {2{scl_s}}) scl_lvl = scl_s;
        if (sda_hist_q == {2{sda_s}}) sda_lvl = sda_s;
    end
`else
    assign scl_lvl = scl_s;
    assign sda_lvl = sda_s;
`endif

    // Previous conditioned level, used for edge and bus-condition decode.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_lvl;
            sda_prev_q <= sda_lvl;
        end
    end

    // SDA may only move while SCL is low; an SDA edge with SCL held high is START/STOP.
    always_comb begin
        scl_rise_o = scl_lvl & ~scl_prev_q;
        scl_fall_o = ~scl_lvl & scl_prev_q;
        start_o    = scl_lvl & scl_prev_q & ~sda_lvl & sda_prev_q;
        stop_o     = scl_lvl & scl_prev_q & sda_lvl & ~sda_prev_q;
        sda_lvl_o  = sda_lvl;
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target with a byte register file, local read port and write notification.
// Optional input glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h42,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned PTR_W       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_o,
    output logic             busy,
    output logic             wr_stb,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    input  logic [PTR_W-1:0] loc_addr,
    output logic [7:0]       loc_rdata
);

    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda_in;

    i2c_target_line_cond u_line_cond (
        .clk_i      (clk),
        .rst_i      (rst),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop),
        .sda_lvl_o  (sda_in)
    );

    state_e           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             rw_q, rw_d;
    logic             sda_q, sda_d;
    logic             busy_q, busy_d;
    logic             wr_stb_q;
    logic [PTR_W-1:0] wr_addr_q;
    logic [7:0]       wr_data_q;
    logic [7:0]       loc_rdata_q;
    logic [7:0]       regs_q [NUM_REGS];
    logic             reg_we;
    logic [7:0]       shift_in;
    logic [7:0]       rd_byte;
    logic             byte_done;
    logic             addr_match;

    assign shift_in   = {shift_q[6:0], sda_in};
    assign rd_byte    = regs_q[ptr_q];
    assign byte_done  = (bit_cnt_q == 4'd8);
    assign addr_match = (shift_q[7:1] == TARGET_ADDR);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state: bus conditions win over bit-level progress; byte phases end on SCL fall.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = StAddr;
        end else if (stop) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StAddr:    if (scl_fall && byte_done) state_d = addr_match ? StAddrAck : StIgnore;
                StAddrAck: if (scl_fall) state_d = (rw_q == RW_WRITE) ? StPtr : StRdData;
                StPtr:     if (scl_fall && byte_done) state_d = StPtrAck;
                StPtrAck:  if (scl_fall) state_d = StWrData;
                StWrData:  if (scl_fall && byte_done) state_d = StWrAck;
                StWrAck:   if (scl_fall) state_d = StWrData;
                StRdData:  if (scl_fall && byte_done) state_d = StRdAck;
                StRdAck: begin
                    // bit_cnt_q == 1 marks that the initiator ACKed on the preceding rise.
                    if (scl_rise && sda_in == NACK)                state_d = StIgnore;
                    else if (scl_fall && bit_cnt_q == 4'd1)        state_d = StRdData;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and output next values: sample on SCL rise, drive SDA after SCL fall.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        sda_d     = sda_q;
        busy_d    = busy_q;
        reg_we    = 1'b0;
        if (start) begin
            bit_cnt_d = '0;
            sda_d     = 1'b1;
        end else if (stop) begin
            bit_cnt_d = '0;
            sda_d     = 1'b1;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                StAddr, StPtr, StWrData: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (state_q == StPtr) ptr_d = shift_in[PTR_W-1:0];
                            if (state_q == StWrData) begin
                                reg_we = 1'b1;
                                ptr_d  = ptr_q + PTR_W'(1);
                            end
                        end
                    end else if (scl_fall && byte_done) begin
                        bit_cnt_d = '0;
                        if (state_q != StAddr) begin
                            sda_d = ACK;
                        end else if (addr_match) begin
                            sda_d  = ACK;
                            busy_d = 1'b1;
                            rw_d   = shift_q[0];
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        if (rw_q == RW_READ) begin
                            shift_d = {rd_byte[6:0], 1'b0};
                            sda_d   = rd_byte[7];
                        end else begin
                            sda_d = 1'b1;
                        end
                    end
                end
                StPtrAck, StWrAck: begin
                    if (scl_fall) sda_d = 1'b1;
                end
                StRdData: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            bit_cnt_d = '0;
                            sda_d     = 1'b1;
                        end else begin
                            sda_d   = shift_q[7];
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        sda_d = 1'b1;
                        if (sda_in == ACK) begin
                            ptr_d     = ptr_q + PTR_W'(1);
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        bit_cnt_d = '0;
                        shift_d   = {rd_byte[6:0], 1'b0};
                        sda_d     = rd_byte[7];
                    end
                end
                default: sda_d = 1'b1;
            endcase
        end
    end

    // Datapath registers, register file and local read port (read sees pre-write data).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_q       <= 1'b1;
            busy_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            loc_rdata_q <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_q       <= sda_d;
            busy_q      <= busy_d;
            wr_stb_q    <= reg_we;
            loc_rdata_q <= regs_q[loc_addr];
            if (reg_we) begin
                regs_q[ptr_q] <= shift_in;
                wr_addr_q     <= ptr_q;
                wr_data_q     <= shift_in;
            end
        end
    end

    assign sda_o     = sda_q;
    assign busy      = busy_q;
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign loc_rdata = loc_rdata_q;

endmodule
